// File: rtl/pwm_audio_out.sv
// Buffers signed 8-bit audio samples in a small FIFO and plays each one as the duty of one 256-count PWM period.
// Define PWM_AUDIO_UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of falling back to midscale silence.
module pwm_audio_out #(
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    sample,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]    DUTY_MID   = 8'd128;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_cnt;
  logic [7:0]    r_duty;
  logic          r_pwm;
  logic          r_underrun;

  logic          w_tick;
  logic          w_boundary;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_headDuty;
  logic [7:0]    w_underrunDuty;

  // Readiness depends only on the registered level, so a pop cannot make room for a same-cycle push.
  assign sample_ready = (r_level < LEVEL_FULL);
  assign w_push       = sample_valid & sample_ready;
  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_boundary   = w_tick & (r_cnt == 8'hFF);
  assign w_pop        = w_boundary & (r_level != '0);
  assign w_headDuty   = {~r_mem[r_rdPtr][7], r_mem[r_rdPtr][6:0]};

  assign pwm_out    = r_pwm;
  assign underrun   = r_underrun;
  assign fifo_level = r_level;

`ifdef PWM_AUDIO_UNDERRUN_HOLD_EN
  logic [7:0] r_lastDuty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastDuty <= DUTY_MID;
    end else if (w_pop) begin
      r_lastDuty <= w_headDuty;
    end
  end

  assign w_underrunDuty = r_lastDuty;
`else
  assign w_underrunDuty = DUTY_MID;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_cnt   <= r_cnt + 8'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A boundary on an empty FIFO still stores a coincident push; that sample plays one period later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_duty     <= DUTY_MID;
      r_pwm      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_pwm      <= (r_cnt < r_duty);
      r_underrun <= w_boundary & (r_level == '0);
      if (w_boundary) begin
        r_duty <= w_pop ? w_headDuty : w_underrunDuty;
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Scoreboard bench for pwm_audio_out: per-period high counts and underrun pulses are queued as samples are issued
// and compared by a monitor at each period end; a second instance (PRESCALE=2) exercises asynchronous reset.
module tb_pwm_audio_out;

`ifdef PWM_AUDIO_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    int highs;
    int unds;
  } expT;

  logic       clk;
  logic       rstA;
  logic [7:0] sampleA;
  logic       validA;
  logic       readyA;
  logic       pwmA;
  logic       underrunA;
  logic [2:0] levelA;

  logic       rstB;
  logic [7:0] sampleB;
  logic       validB;
  logic       readyB;
  logic       pwmB;
  logic       underrunB;
  logic [2:0] levelB;

  int  checks = 0;
  int  errors = 0;
  int  eA = 0;
  int  pwmAcc = 0;
  int  undAcc = 0;
  int  periodsDone = 0;
  bit  monOn = 1'b0;
  expT expQ[$];

  pwm_audio_out #(.FIFO_DEPTH(4), .PRESCALE(1)) dut (
    .clk(clk), .reset(rstA), .sample(sampleA), .sample_valid(validA),
    .sample_ready(readyA), .pwm_out(pwmA), .underrun(underrunA), .fifo_level(levelA)
  );

  pwm_audio_out #(.FIFO_DEPTH(4), .PRESCALE(2)) dutB (
    .clk(clk), .reset(rstB), .sample(sampleB), .sample_valid(validB),
    .sample_ready(readyB), .pwm_out(pwmB), .underrun(underrunB), .fifo_level(levelB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter for the main instance: value N at a negedge means N rising edges since reset release.
  always @(posedge clk) begin
    if (rstA) eA <= 0;
    else      eA <= eA + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int highs, input int unds);
    expT e;
    e.highs = highs;
    e.unds  = unds;
    expQ.push_back(e);
  endtask

  // Drives one sample on the main instance for exactly one rising edge, starting at the current negedge.
  task automatic applyStimulus(input logic [7:0] s);
    sampleA = s;
    validA  = 1'b1;
    @(negedge clk);
    validA  = 1'b0;
  endtask

  task automatic waitE(input int n);
    while (eA < n) @(negedge clk);
  endtask

  // Period k covers pwm samples after edges 256k+1..256k+256 and underrun samples after edges 256k..256k+255.
  always @(negedge clk) begin
    if (monOn) begin
      if (eA >= 1) pwmAcc += int'(pwmA);
      if (eA >= 256 && (eA % 256) == 0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL period%0d: got a period end, expected no more periods", periodsDone);
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput($sformatf("period%0d_highs", periodsDone), pwmAcc, e.highs);
          checkOutput($sformatf("period%0d_underrun", periodsDone), undAcc, e.unds);
        end
        pwmAcc = 0;
        undAcc = 0;
        periodsDone++;
      end
      undAcc += int'(underrunA);
    end
  end

  initial begin
    int n;
    rstA = 1'b1; sampleA = 8'h00; validA = 1'b0;
    rstB = 1'b1; sampleB = 8'h00; validB = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("resetA_pwm", int'(pwmA), 0);
    checkOutput("resetA_underrun", int'(underrunA), 0);
    checkOutput("resetA_ready", int'(readyA), 1);
    checkOutput("resetA_level", int'(levelA), 0);

    rstA  = 1'b0;
    monOn = 1'b1;
    pushExp(128, 0);

    waitE(10);
    applyStimulus(8'h00); pushExp(128, 0);
    applyStimulus(8'h80); pushExp(0, 0);
    applyStimulus(8'h7F); pushExp(255, 0);

    waitE(800);
    applyStimulus(8'hF0); pushExp(112, 0);
    applyStimulus(8'hC0); pushExp(64, 0);
    applyStimulus(8'h10); pushExp(144, 0);
    applyStimulus(8'h40); pushExp(192, 0);
    checkOutput("full_level", int'(levelA), 4);
    checkOutput("full_ready", int'(readyA), 0);
    applyStimulus(8'h55);
    checkOutput("drop_level", int'(levelA), 4);
    checkOutput("drop_ready", int'(readyA), 0);
    pushExp(HOLD ? 192 : 128, 1);

    waitE(2303);
    pushExp(HOLD ? 192 : 128, 1);
    applyStimulus(8'hE0);
    checkOutput("coincide_level", int'(levelA), 1);
    checkOutput("coincide_underrun", int'(underrunA), 1);
    pushExp(96, 0);
    pushExp(HOLD ? 96 : 128, 1);

    n = 0;
    while (periodsDone < 12 && n < 3500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("periods_seen", periodsDone, 12);
    checkOutput("queue_drained", expQ.size(), 0);
    monOn = 1'b0;

    rstB = 1'b0;
    sampleB = 8'h7F;
    validB  = 1'b1;
    repeat (4) @(negedge clk);
    validB  = 1'b0;
    repeat (592) @(negedge clk);
    checkOutput("B_midperiod_level", int'(levelB), 3);
    checkOutput("B_midperiod_pwm", int'(pwmB), 1);

    #2 rstB = 1'b1;
    #1;
    checkOutput("B_async_pwm", int'(pwmB), 0);
    checkOutput("B_async_underrun", int'(underrunB), 0);
    checkOutput("B_async_ready", int'(readyB), 1);
    checkOutput("B_async_level", int'(levelB), 0);

    @(negedge clk);
    rstB = 1'b0;
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (underrunB) break;
    end
    checkOutput("B_first_boundary_edge", n, 512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter PRESCALE, default 1, meaning clk cycles per PWM count step (1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sample  input  8  signed two's-complement audio sample from sound_card combined output.
REQ-006 SHALL have port sample_valid  input  1  sample present this cycle.
REQ-007 SHALL have port sample_ready  output  1  FIFO can accept a sample (level < FIFO_DEPTH).
REQ-008 SHALL have port pwm_out  output  1  registered PWM audio bit.
REQ-009 SHALL have port underrun  output  1  one-cycle pulse when a period starts with FIFO empty.
REQ-010 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-011 SHALL accept (push) a sample on a rising edge where sample_valid=1 and sample_ready=1; otherwise the sample is ignored.
REQ-012 SHALL compute sample_ready from the current level only; a push while full SHALL be dropped even if a pop occurs the same cycle.
REQ-013 SHALL convert a popped sample to unsigned duty by inverting its MSB (-128->0, 0->128, +127->255).
REQ-014 SHALL run a prescaler counting 0..PRESCALE-1; tick asserted on the cycle the prescaler equals PRESCALE-1, then wraps to 0.
REQ-015 SHALL advance 8-bit PWM counter cnt by 1 on each tick, wrapping 255->0.
REQ-016 SHALL define period boundary as a tick with cnt=255; on that edge cnt becomes 0 and duty_reg is reloaded.
REQ-017 SHALL, at a boundary with FIFO non-empty, pop the head entry into duty_reg (FIFO order preserved).
REQ-018 SHALL, at a boundary with FIFO empty, pulse underrun high for exactly the following cycle and apply REQ-026/REQ-027 to duty_reg.
REQ-019 SHALL, on simultaneous push and boundary with FIFO empty, register underrun and store the pushed sample (level becomes 1).
REQ-020 SHALL, on simultaneous push and pop with FIFO neither empty nor full, leave level unchanged.
REQ-021 SHALL drive pwm_out registered: pwm_out(t+1) = (cnt(t) < duty_reg(t)); duty 0 gives constant low, duty 255 high 255 of 256 counts.
REQ-022 SHALL keep fifo_level equal to pushes minus pops since reset, never exceeding FIFO_DEPTH.

Reset
REQ-023 SHALL, while reset=1 (asynchronously), force cnt=0, prescaler=0, FIFO empty (level 0, pointers 0), duty_reg=128, last sample=128.
REQ-024 SHALL, while reset=1, drive pwm_out=0, underrun=0, sample_ready=1, fifo_level=0.
REQ-025 SHALL, on reset asserted mid-period or with data buffered, discard all buffered samples; first boundary after release occurs 256*PRESCALE cycles later.

Configuration
REQ-026 SHALL, with macro PWM_AUDIO_UNDERRUN_HOLD_EN defined, keep duty_reg at the last popped duty on underrun (repeat last sample).
REQ-027 SHALL, without PWM_AUDIO_UNDERRUN_HOLD_EN, load duty_reg=128 (midscale silence) on underrun; underrun pulse identical in both builds.

Verification
REQ-028 SHALL test: PRESCALE=1, push 8'h00 then wait a period -> next period pwm_out high exactly 128 of 256 cycles.
REQ-029 SHALL test: push 8'h80 (-128) and 8'h7F -> period with 0 high cycles, then period with 255 high cycles, underrun never pulses.
REQ-030 SHALL test: push 5 samples back-to-back with FIFO_DEPTH=4 -> sample_ready low after 4th, 5th dropped, fifo_level=4.
REQ-031 SHALL test: no pushes after one sample 8'h40 -> underrun one-cycle pulse at next boundary; duty 192 held with HOLD_EN, 128 without.
REQ-032 SHALL test: push coincident with boundary on empty FIFO -> underrun pulses, fifo_level=1, sample played next period.
REQ-033 SHALL test: reset asserted mid-period with level 3, PRESCALE=2 -> outputs at reset values immediately, next boundary 512 cycles after release.
